// File: rtl/csr_neighbor_fetcher_if.sv
// csr_neighbor_fetcher_if: processing-unit fetch handshake plus graph-memory read bus
interface csr_neighbor_fetcher_if #(
  parameter int NODE_BITS = 32,
  parameter int ADDR_BITS = 32
);
  logic                 fetch_en;
  logic [NODE_BITS-1:0] fetch_node_id;
  logic                 fetch_done;
  logic [NODE_BITS-1:0] neighbor_id;
  logic                 neighbor_valid;
  logic                 mem_rd_en;
  logic [ADDR_BITS-1:0] mem_rd_addr;
  logic                 mem_rd_ready;
  logic                 mem_rd_valid;
  logic [NODE_BITS-1:0] mem_rd_data;
  modport slave (
    input  fetch_en, fetch_node_id, mem_rd_ready, mem_rd_valid, mem_rd_data,
    output fetch_done, neighbor_id, neighbor_valid, mem_rd_en, mem_rd_addr
  );
  modport master (
    output fetch_en, fetch_node_id, mem_rd_ready, mem_rd_valid, mem_rd_data,
    input  fetch_done, neighbor_id, neighbor_valid, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/csr_neighbor_fetcher.sv
// csr_neighbor_fetcher: expands one node's CSR row into neighbor beats plus a terminal beat
module csr_neighbor_fetcher #(
  parameter int NODE_BITS = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  csr_neighbor_fetcher_if.slave bus,
  input  logic [ADDR_BITS-1:0] cfg_row_base,
  input  logic [ADDR_BITS-1:0] cfg_col_base,
  input  logic [NODE_BITS-1:0] cfg_num_nodes,
  output logic                 err
);
  typedef enum logic [2:0] {IDLE, CHK, RD_START, RD_END, RD_NBR, PRESENT, TERM} state_t;
  state_t state, state_nx;
  logic [NODE_BITS-1:0] v, start_q, end_q, idx, nbr;
  logic pend, armed, rsp, beat;
  always_comb begin
    rsp = bus.mem_rd_valid && pend;
    beat = bus.fetch_en && armed && (state == PRESENT || state == TERM);
    bus.mem_rd_en = !pend && (state == RD_START || state == RD_END || state == RD_NBR);
    bus.mem_rd_addr = !bus.mem_rd_en ? '0
      : state == RD_NBR ? cfg_col_base + ADDR_BITS'(idx)
      : cfg_row_base + ADDR_BITS'(v) + ADDR_BITS'(state == RD_END);
    bus.fetch_done = beat;
    bus.neighbor_valid = beat && state == PRESENT;
    bus.neighbor_id = bus.neighbor_valid ? nbr : '0;
    err = (state == CHK && v >= cfg_num_nodes) || (state == RD_END && rsp && bus.mem_rd_data < start_q);
    state_nx = state == IDLE ? (bus.fetch_en ? CHK : IDLE)
      : state == CHK ? (v >= cfg_num_nodes ? TERM : RD_START)
      : state == RD_START ? (rsp ? RD_END : RD_START)
      : state == RD_END ? (!rsp ? RD_END : bus.mem_rd_data > start_q ? RD_NBR : TERM)
      : state == RD_NBR ? (rsp ? PRESENT : RD_NBR)
      : state == PRESENT ? (!beat ? PRESENT : idx < end_q ? RD_NBR : TERM)
      : (beat ? IDLE : TERM);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      start_q <= '0;
      end_q <= '0;
      idx <= '0;
      nbr <= '0;
      pend <= 1'b0;
      armed <= 1'b0;
    end else begin
      pend <= bus.mem_rd_en && bus.mem_rd_ready ? 1'b1 : rsp ? 1'b0 : pend;
      armed <= state == IDLE || (!beat && (armed || !bus.fetch_en));
      if (state == IDLE && bus.fetch_en) v <= bus.fetch_node_id;
      if (state == RD_START && rsp) start_q <= bus.mem_rd_data;
      if (state == RD_END && rsp) begin
        end_q <= bus.mem_rd_data;
        idx <= start_q;
      end
      if (state == RD_NBR && rsp) begin
        nbr <= bus.mem_rd_data;
        idx <= idx + NODE_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_csr_neighbor_fetcher.sv
// tb_csr_neighbor_fetcher: scoreboard bench driving a processing-unit model against a CSR graph memory
module tb_csr_neighbor_fetcher;
  typedef struct {logic v; logic [31:0] id;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  logic [31:0] mem [0:1023];
  beat_t exp_q[$];
  logic [31:0] rd_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int lat = 1;
  int cnt = 0;
  logic [31:0] rdata;
  csr_neighbor_fetcher_if bus();
  csr_neighbor_fetcher dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cfg_row_base(32'h100),
    .cfg_col_base(32'h200),
    .cfg_num_nodes(32'd3),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
      bus.mem_rd_valid <= 1'b0;
      bus.mem_rd_data <= '0;
    end else begin
      bus.mem_rd_valid <= 1'b0;
      if (bus.mem_rd_en && bus.mem_rd_ready) begin
        if (lat == 1) begin
          bus.mem_rd_valid <= 1'b1;
          bus.mem_rd_data <= mem[bus.mem_rd_addr[9:0]];
        end else begin
          cnt <= lat - 1;
          rdata <= mem[bus.mem_rd_addr[9:0]];
        end
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          bus.mem_rd_valid <= 1'b1;
          bus.mem_rd_data <= rdata;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fetch_done) begin
        done_cnt++;
        check("beat expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("neighbor_valid", 32'(bus.neighbor_valid), 32'(e.v));
          check("neighbor_id", bus.neighbor_id, e.id);
        end
      end
      if (bus.mem_rd_en && bus.mem_rd_ready) begin
        check("read expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) check("mem_rd_addr", bus.mem_rd_addr, rd_q.pop_front());
      end
      if (err) err_cnt++;
    end
  end
  task automatic push_beats(input logic [31:0] ids[$]);
    foreach (ids[i]) exp_q.push_back('{1'b1, ids[i]});
    exp_q.push_back('{1'b0, 32'd0});
  endtask
  task automatic push_reads(input logic [31:0] a[$]);
    foreach (a[i]) rd_q.push_back(a[i]);
  endtask
  task automatic pu_loop(output int first);
    bit term = 0;
    int t = 0;
    first = -1;
    while (!term && t < 400) begin
      @(negedge clk);
      t++;
      if (bus.fetch_done) begin
        if (first < 0) first = t - 1;
        term = !bus.neighbor_valid;
        @(posedge clk);
        #1;
        bus.fetch_en = 1'b0;
        if (!term) begin
          bus.fetch_node_id = 32'hdead_beef;
          repeat (2) @(posedge clk);
          #1;
          bus.fetch_en = 1'b1;
        end
      end
    end
    check("session terminated", 32'(term), 1);
  endtask
  task automatic session(input logic [31:0] node, output int first);
    @(posedge clk);
    #1;
    bus.fetch_node_id = node;
    bus.fetch_en = 1'b1;
    pu_loop(first);
  endtask
  task automatic finish_scn(input string name, input int exp_done, input int exp_err);
    repeat (3) @(negedge clk);
    check({name, " beats left"}, exp_q.size(), 0);
    check({name, " reads left"}, rd_q.size(), 0);
    check({name, " fetch_done count"}, done_cnt, exp_done);
    check({name, " err count"}, err_cnt, exp_err);
    done_cnt = 0;
    err_cnt = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int first;
    bit found;
    logic [31:0] held;
    mem[10'h100] = 0; mem[10'h101] = 2; mem[10'h102] = 2; mem[10'h103] = 5;
    mem[10'h200] = 1; mem[10'h201] = 2; mem[10'h202] = 0; mem[10'h203] = 1; mem[10'h204] = 2;
    bus.fetch_en = 1'b0;
    bus.fetch_node_id = '0;
    bus.mem_rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset fetch_done", 32'(bus.fetch_done), 0);
    check("reset neighbor_valid", 32'(bus.neighbor_valid), 0);
    check("reset neighbor_id", bus.neighbor_id, 0);
    check("reset mem_rd_en", 32'(bus.mem_rd_en), 0);
    check("reset mem_rd_addr", bus.mem_rd_addr, 0);
    check("reset err", 32'(err), 0);
    push_beats('{32'd1, 32'd2});
    push_reads('{32'h100, 32'h101, 32'h200, 32'h201});
    session(0, first);
    check("node0 first-beat latency", first, 8);
    finish_scn("node0", 3, 0);
    push_beats('{});
    push_reads('{32'h101, 32'h102});
    session(1, first);
    finish_scn("node1", 1, 0);
    push_beats('{});
    session(5, first);
    finish_scn("node5", 1, 1);
    push_beats('{32'd0, 32'd1, 32'd2});
    push_reads('{32'h102, 32'h103, 32'h202, 32'h203, 32'h204});
    @(posedge clk);
    #1;
    bus.fetch_node_id = 2;
    bus.fetch_en = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("held-high single beat", done_cnt, 1);
    bus.fetch_en = 1'b0;
    @(posedge clk);
    #1;
    bus.fetch_en = 1'b1;
    pu_loop(first);
    finish_scn("held", 4, 0);
    lat = 3;
    bus.mem_rd_ready = 1'b0;
    push_beats('{32'd0, 32'd1, 32'd2});
    push_reads('{32'h102, 32'h103, 32'h202, 32'h203, 32'h204});
    fork
      session(2, first);
      begin
        found = 0;
        for (int t = 0; t < 50 && !found; t++) begin
          @(negedge clk);
          found = bus.mem_rd_en;
        end
        check("stall read requested", 32'(found), 1);
        held = bus.mem_rd_addr;
        check("stall first addr", held, 32'h102);
        repeat (4) begin
          @(negedge clk);
          check("stall mem_rd_en held", 32'(bus.mem_rd_en), 1);
          check("stall addr stable", bus.mem_rd_addr, held);
        end
        @(posedge clk);
        #1;
        bus.mem_rd_ready = 1'b1;
      end
    join
    finish_scn("stall", 4, 0);
    push_reads('{32'h102, 32'h103, 32'h202});
    @(posedge clk);
    #1;
    bus.fetch_node_id = 2;
    bus.fetch_en = 1'b1;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      found = bus.mem_rd_en && bus.mem_rd_addr == 32'h202;
    end
    check("column read issued", 32'(found), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.fetch_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid reset fetch_done", 32'(bus.fetch_done), 0);
    check("mid reset neighbor_valid", 32'(bus.neighbor_valid), 0);
    check("mid reset neighbor_id", bus.neighbor_id, 0);
    check("mid reset mem_rd_en", 32'(bus.mem_rd_en), 0);
    check("mid reset mem_rd_addr", bus.mem_rd_addr, 0);
    check("mid reset err", 32'(err), 0);
    push_beats('{32'd1, 32'd2});
    push_reads('{32'h100, 32'h101, 32'h200, 32'h201});
    session(0, first);
    finish_scn("after reset", 3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/csr_neighbor_fetcher.md
# csr_neighbor_fetcher

- Responder end of the processing-unit fetch interface.
- Accepts one node ID per session from a processing unit.
- Reads that node's CSR row bounds and column indices from graph memory, then returns the neighbors one per handshake beat, followed by a terminal end-of-list beat.
- Sits between each processing unit and the shared graph-memory read port.

## Interface
Parameters:
- NODE_BITS, 32, width of node IDs and CSR words
- ADDR_BITS, 32, word address width of graph memory

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- fetch_en  in  1  request level from processing unit
- fetch_node_id  in  NODE_BITS  node to expand; sampled only at session start
- fetch_done  out  1  one-cycle beat strobe
- neighbor_id  out  NODE_BITS  neighbor value; meaningful only when fetch_done=1 and neighbor_valid=1
- neighbor_valid  out  1  1 = neighbor beat, 0 = terminal beat; qualified by fetch_done
- cfg_row_base  in  ADDR_BITS  word address of row_ptr[0]
- cfg_col_base  in  ADDR_BITS  word address of col_idx[0]
- cfg_num_nodes  in  NODE_BITS  number of valid node IDs
- mem_rd_en  out  1  read request
- mem_rd_addr  out  ADDR_BITS  word address
- mem_rd_ready  in  1  request accepted when mem_rd_en && mem_rd_ready
- mem_rd_valid  in  1  response strobe, in order
- mem_rd_data  in  NODE_BITS  response word
- err  out  1  one-cycle pulse on a bad node ID or a bad row

## Operation
- Reset values: fetch_done=0, neighbor_valid=0, neighbor_id=0, mem_rd_en=0, mem_rd_addr=0, err=0, state IDLE, buffer empty.
- Memory port:
  - At most one read outstanding.
  - mem_rd_en is held with a stable mem_rd_addr until accepted.
  - A mem_rd_valid with no read outstanding is ignored.
- IDLE:
  - When fetch_en=1, latch v=fetch_node_id and go to CHK.
- CHK:
  - If v >= cfg_num_nodes: pulse err and go to TERM.
  - Otherwise read cfg_row_base+v (RD_START).
- RD_START / RD_END:
  - Store start=row_ptr[v], then read cfg_row_base+v+1 and store end=row_ptr[v+1].
  - If end < start: pulse err and go to TERM.
  - If end == start: go to TERM.
  - Otherwise set idx=start and go to RD_NBR.
- RD_NBR:
  - Read cfg_col_base+idx.
  - On response, load the one-entry buffer, increment idx, and go to PRESENT.
- PRESENT:
  - Waits for fetch_en=1 with the handshake armed (see Timing).
  - Then emits the neighbor beat: fetch_done=1, neighbor_valid=1, neighbor_id=buffer; the buffer empties.
  - Same cycle, go to RD_NBR if idx < end, else TERM.
  - Prefetch: the next column read is issued while the processing unit is outside its fetch state.
- TERM:
  - Waits for fetch_en=1 with the handshake armed.
  - Then emits the terminal beat: fetch_done=1, neighbor_valid=0, neighbor_id=0.
  - Returns to IDLE.
- Address arithmetic is modulo 2^ADDR_BITS; no overflow check.
- Every beat is one cycle. No beat is ever issued while fetch_en=0.

## Timing
- Arming rule:
  - The handshake is armed at session start.
  - After any beat it is disarmed, and re-arms once fetch_en has been sampled 0 for at least one cycle.
  - This matches the processing unit's fetch, check, push, fetch sequence: at most one beat per fetch_en high period.
- First-beat latency, zero-wait memory (ready=1, valid one cycle after accept):
  - fetch_en sampled in IDLE at cycle 0.
  - Row reads at cycles 2 and 4, column read at cycle 6.
  - fetch_done at cycle 8.
- Subsequent beats:
  - Emitted on the first cycle fetch_en is high and armed, provided the prefetched word has arrived.
  - Otherwise emitted the cycle after mem_rd_valid.
- Boundary cases:
  - fetch_en drops mid-session: the session continues and the next beat waits.
  - fetch_node_id changes mid-session: ignored.
  - fetch_en=1 in the terminal-beat cycle: IDLE is not entered until the next cycle, and no new session starts in the same cycle.
- Reset mid-session:
  - Returns to IDLE, clears the outstanding flag and the buffer, and produces no beat.
  - Graph memory shares rst.
- err is asserted in the same cycle as the state decision.
- When err fires, the terminal beat still follows.

## Test plan
Memory for all scenarios:
- row_ptr at 0x100 = [0,2,2,5]; col_idx at 0x200 = [1,2,0,1,2]; cfg_num_nodes=3.

Scenarios:
- Node 0, processing-unit model cycling fetch/check/push -> beats (1,valid), (2,valid), then terminal; exactly 3 fetch_done pulses; reads at 0x100, 0x101, 0x200, 0x201.
- Node 1 (zero degree) -> single terminal beat, no column read, err=0.
- Node 5 (>= num_nodes) -> err pulse, then terminal beat, no memory reads.
- Node 2 with fetch_en held high continuously -> exactly one beat (0,valid), then no further fetch_done until fetch_en is low for one cycle.
- Node 2 with mem_rd_ready low for 4 cycles and a 3-cycle response latency -> mem_rd_addr stays stable while stalled; beats 0, 1, 2 in order, then terminal.
- rst pulsed while the column read for node 2 is outstanding -> all outputs 0 next cycle; a new session for node 0 returns 1, 2, then terminal.
